// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle controller: instruction fields and
// flags in, strobes and mux selects out.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;

    // Controller side
    modport master (
        input  opcode, funct3, funct7_5, zero,
        output pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
    );

    // Datapath side
    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  pc_write, ir_write, reg_write, mem_write, adr_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle RISC-V controller (lw, sw, R-type, I-type, beq, jal).
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on unsupported opcodes instead of NOP.
module multicycle_ctrl (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master ctrl
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state_q, state_d;
    // Opcode is only valid in DECODE, so lw/sw is remembered for MEMADR.
    logic   is_sw_q, is_sw_d;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       op5,
                                              input logic       f7_5);
        case (f3)
            3'b000:  return (op5 && f7_5) ? ALU_SUB : ALU_ADD;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        is_sw_d          = is_sw_q;
        ctrl.pc_write    = 1'b0;
        ctrl.ir_write    = 1'b0;
        ctrl.reg_write   = 1'b0;
        ctrl.mem_write   = 1'b0;
        ctrl.adr_src     = 1'b0;
        ctrl.alu_src_a   = 2'b00;
        ctrl.alu_src_b   = 2'b00;
        ctrl.result_src  = 2'b00;
        ctrl.imm_src     = 2'b00;
        ctrl.alu_control = ALU_ADD;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        ctrl.illegal     = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.alu_src_b  = 2'b10;
                ctrl.result_src = 2'b10;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b01;
                ctrl.imm_src   = 2'b10;
                is_sw_d        = ctrl.opcode[5];
                case (ctrl.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 2'b10;
                ctrl.alu_src_b = 2'b01;
                ctrl.imm_src   = is_sw_q ? 2'b01 : 2'b00;
                state_d        = is_sw_q ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.result_src = 2'b01;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECR: begin
                ctrl.alu_src_a   = 2'b10;
                ctrl.alu_control = alu_decode(ctrl.funct3, ctrl.opcode[5], ctrl.funct7_5);
                state_d          = S_ALUWB;
            end
            S_EXECI: begin
                ctrl.alu_src_a   = 2'b10;
                ctrl.alu_src_b   = 2'b01;
                ctrl.alu_control = alu_decode(ctrl.funct3, ctrl.opcode[5], ctrl.funct7_5);
                state_d          = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ: begin
                // The only Mealy output: branch taken straight from the ALU flag.
                ctrl.alu_src_a   = 2'b10;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_write    = ctrl.zero;
                state_d          = S_FETCH;
            end
            S_JAL: begin
                ctrl.alu_src_a = 2'b01;
                ctrl.alu_src_b = 2'b10;
                ctrl.pc_write  = 1'b1;
                state_d        = S_ALUWB;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl.illegal = 1'b1;
                state_d      = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    assign ctrl.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand sequences for reset
// abort and illegal opcodes, then random instruction streams against a model.
module tb_multicycle_ctrl;
    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] res;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       z;
        int         len;
        logic       chk_alu;
        logic [2:0] alu_exp;
        logic       chk_pcw;
        logic       pcw_exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f75);
        if (f3 == 3'b000) return (op[5] && f75) ? A_SUB : A_ADD;
        if (f3 == 3'b110) return A_OR;
        if (f3 == 3'b111) return A_AND;
        return A_ADD;
    endfunction

    function automatic int seq_len(input logic [6:0] op);
        case (op)
            LW:         return 5;
            SW, RT, IT, JL: return 4;
            BQ:         return 3;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            default:    return 12;
`else
            default:    return 2;
`endif
        endcase
    endfunction

    // Phase ids: 0 FETCH 1 DECODE 2 MEMADR 3 MEMREAD 4 MEMWB 5 MEMWRITE
    // 6 EXECR 7 EXECI 8 ALUWB 9 BEQ 10 JAL 11 TRAP
    function automatic int phase_at(input logic [6:0] op, input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        case (op)
            LW:      return (k == 2) ? 2 : (k == 3) ? 3 : 4;
            SW:      return (k == 2) ? 2 : 5;
            RT:      return (k == 2) ? 6 : 8;
            IT:      return (k == 2) ? 7 : 8;
            BQ:      return 9;
            JL:      return (k == 2) ? 10 : 8;
            default: return 11;
        endcase
    endfunction

    function automatic out_t exp_out(input int ph, input logic [6:0] op, input logic [2:0] f3,
                                     input logic f75, input logic z);
        out_t o;
        o = '0;
        case (ph)
            0:  begin o.pc_write = 1'b1; o.ir_write = 1'b1; o.b = 2'b10; o.res = 2'b10; end
            1:  begin o.a = 2'b01; o.b = 2'b01; o.imm = 2'b10; end
            2:  begin o.a = 2'b10; o.b = 2'b01; o.imm = (op == SW) ? 2'b01 : 2'b00; end
            3:  o.adr_src = 1'b1;
            4:  begin o.res = 2'b01; o.reg_write = 1'b1; end
            5:  begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
            6:  begin o.a = 2'b10; o.alu = ref_alu(op, f3, f75); end
            7:  begin o.a = 2'b10; o.b = 2'b01; o.alu = ref_alu(op, f3, f75); end
            8:  o.reg_write = 1'b1;
            9:  begin o.a = 2'b10; o.alu = A_SUB; o.pc_write = z; end
            10: begin o.a = 2'b01; o.b = 2'b10; o.pc_write = 1'b1; end
            default: o.illegal = 1'b1;
        endcase
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.pc_write  = bus.pc_write;
        o.ir_write  = bus.ir_write;
        o.reg_write = bus.reg_write;
        o.mem_write = bus.mem_write;
        o.adr_src   = bus.adr_src;
        o.a         = bus.alu_src_a;
        o.b         = bus.alu_src_b;
        o.res       = bus.result_src;
        o.imm       = bus.imm_src;
        o.alu       = bus.alu_control;
        o.illegal   = bus.illegal;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = dut_out();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // Entry: just after a rising edge with the DUT in FETCH. Inputs that must be
    // ignored are scrambled; the instruction's own fields appear only where read.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic z, input int ncyc, input string name,
                             output out_t o2);
        int ph;
        o2 = '0;
        for (int k = 0; k < ncyc; k++) begin
            ph = phase_at(op, k);
            if (k == 1 || ph == 6 || ph == 7) begin
                bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75;
            end else begin
                bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom);
                bus.funct7_5 = 1'($urandom);
            end
            bus.zero = (ph == 9) ? z : 1'($urandom);
            #1;
            check_out($sformatf("%s_c%0d", name, k), exp_out(ph, op, f3, f75, z));
            if (k == 2) o2 = dut_out();
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {LW, SW, RT, IT, BQ, JL};
    endfunction

    vec_t tbl[$];
    out_t o2;
    out_t fetch_o;

    initial begin
        fetch_o = exp_out(0, 7'd0, 3'd0, 1'b0, 1'b0);
        bus.opcode = LW; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.zero = 1'b0;

        //            op   f3      f75   z     len chkA  aluExp chkP pcwExp name
        tbl.push_back('{LW, 3'b010, 1'b0, 1'b0, 5, 1'b0, A_ADD, 1'b0, 1'b0, "lw"});
        tbl.push_back('{SW, 3'b010, 1'b0, 1'b0, 4, 1'b0, A_ADD, 1'b0, 1'b0, "sw"});
        tbl.push_back('{RT, 3'b000, 1'b1, 1'b0, 4, 1'b1, A_SUB, 1'b0, 1'b0, "r_sub"});
        tbl.push_back('{RT, 3'b000, 1'b0, 1'b0, 4, 1'b1, A_ADD, 1'b0, 1'b0, "r_add"});
        tbl.push_back('{RT, 3'b111, 1'b0, 1'b0, 4, 1'b1, A_AND, 1'b0, 1'b0, "r_and"});
        tbl.push_back('{RT, 3'b110, 1'b1, 1'b0, 4, 1'b1, A_OR,  1'b0, 1'b0, "r_or"});
        tbl.push_back('{RT, 3'b100, 1'b1, 1'b0, 4, 1'b1, A_ADD, 1'b0, 1'b0, "r_xor_add"});
        tbl.push_back('{IT, 3'b000, 1'b1, 1'b0, 4, 1'b1, A_ADD, 1'b0, 1'b0, "i_addi"});
        tbl.push_back('{IT, 3'b111, 1'b0, 1'b0, 4, 1'b1, A_AND, 1'b0, 1'b0, "i_andi"});
        tbl.push_back('{BQ, 3'b000, 1'b0, 1'b1, 3, 1'b1, A_SUB, 1'b1, 1'b1, "beq_taken"});
        tbl.push_back('{BQ, 3'b000, 1'b0, 1'b0, 3, 1'b1, A_SUB, 1'b1, 1'b0, "beq_not"});
        tbl.push_back('{JL, 3'b000, 1'b0, 1'b0, 4, 1'b0, A_ADD, 1'b1, 1'b1, "jal"});
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        tbl.push_back('{BAD, 3'b000, 1'b0, 1'b0, 2, 1'b0, A_ADD, 1'b0, 1'b0, "illegal_nop"});
`endif

        // Reset: FETCH decode visible, ILLEGAL low
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_fetch", fetch_o);
        check_bit("reset_illegal", bus.illegal, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f75, tbl[i].z, tbl[i].len, tbl[i].name, o2);
            if (tbl[i].chk_alu) begin
                n_checks++;
                if (o2.alu === tbl[i].alu_exp) n_pass++;
                else $display("FAIL %s_alu: got %b expected %b", tbl[i].name, o2.alu, tbl[i].alu_exp);
            end
            if (tbl[i].chk_pcw) check_bit({tbl[i].name, "_pcw"}, o2.pc_write, tbl[i].pcw_exp);
            #1;
            check_out({tbl[i].name, "_back_fetch"}, fetch_o);
        end

        // Reset in MEMWRITE aborts the store immediately
        run_instr(SW, 3'b010, 1'b0, 1'b0, 3, "sw_abort", o2);
        #1;
        check_bit("memwrite_before_rst", bus.mem_write, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_out("abort_fetch", fetch_o);
        check_bit("abort_mem_write", bus.mem_write, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 5, "lw_after_abort", o2);

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        // FETCH, DECODE, then 10 trapped cycles; only reset leaves
        run_instr(BAD, 3'b000, 1'b0, 1'b0, 12, "trap", o2);
        #1;
        check_bit("trap_still_illegal", bus.illegal, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("trap_rst_illegal", bus.illegal, 1'b0);
        check_out("trap_rst_fetch", fetch_o);
        @(posedge clk);
        #1 rst = 1'b0;
`else
        run_instr(BAD, 3'b000, 1'b0, 1'b0, 2, "bad_nop", o2);
        #1;
        check_out("bad_nop_fetch", fetch_o);
        check_bit("bad_nop_illegal", bus.illegal, 1'b0);
`endif

        // Random instruction stream
        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f75;
            logic       z;
            case ($urandom_range(0, 7))
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = IT;
                4: op = BQ;
                5: op = JL;
                6: op = RT;
                default: begin
                    op = 7'($urandom);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    if (!is_legal(op)) op = IT;
`endif
                end
            endcase
            f3  = 3'($urandom);
            f75 = 1'($urandom);
            z   = 1'($urandom);
            run_instr(op, f3, f75, z, seq_len(op), $sformatf("rnd%0d_%b", n, op), o2);
        end
        #1;
        check_out("rnd_end_fetch", fetch_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
